// File: rtl/multicycle_control_if.sv
// Handshake and control bundle between the multicycle controller and its datapath.
// The master side is the controller, and the slave side is the datapath.
interface multicycle_control_if #(
    parameter int CONTROL_WIDTH = 4,
    parameter int DATA_WIDTH    = 32
);
    logic [DATA_WIDTH-1:0]    Instr;
    logic                     Zero;
    logic                     MemReady;
    logic                     PCWrite;
    logic                     IRWrite;
    logic                     MemRead;
    logic                     MemWrite;
    logic                     RegWrite;
    logic                     AdrSrc;
    logic [1:0]               ALUSrcA;
    logic [1:0]               ALUSrcB;
    logic [1:0]               ResultSrc;
    logic [2:0]               ImmSrc;
    logic [CONTROL_WIDTH-1:0] ALUctrl;
    logic                     IllegalInstr;

    modport master (
        input  Instr, Zero, MemReady,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUctrl, IllegalInstr
    );

    modport slave (
        output Instr, Zero, MemReady,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUctrl, IllegalInstr
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle RV32I-subset datapath.
// The state register is the only flop. The outputs are decoded from the state, and reset masks the write strobes.
module multicycle_control #(
    parameter int CONTROL_WIDTH = 4,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
        S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR = 4'd6,  S_EXECI  = 4'd7,
        S_ALUWB    = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
        S_UPPER    = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011, OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    localparam logic [CONTROL_WIDTH-1:0] ALU_ADD  = CONTROL_WIDTH'(4'b0000);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SUB  = CONTROL_WIDTH'(4'b0001);
    localparam logic [CONTROL_WIDTH-1:0] ALU_XOR  = CONTROL_WIDTH'(4'b0010);
    localparam logic [CONTROL_WIDTH-1:0] ALU_OR   = CONTROL_WIDTH'(4'b0011);
    localparam logic [CONTROL_WIDTH-1:0] ALU_AND  = CONTROL_WIDTH'(4'b0100);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLL  = CONTROL_WIDTH'(4'b0101);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SRL  = CONTROL_WIDTH'(4'b0110);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SRA  = CONTROL_WIDTH'(4'b0111);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLT  = CONTROL_WIDTH'(4'b1000);
    localparam logic [CONTROL_WIDTH-1:0] ALU_SLTU = CONTROL_WIDTH'(4'b1001);
    localparam logic [CONTROL_WIDTH-1:0] ALU_BEQ  = CONTROL_WIDTH'(4'b1010);

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] instr_s;
    logic [6:0]            opcode_s;
    logic [2:0]            funct3_s;
    logic [6:0]            funct7_s;
    logic                  alt_s;
    logic                  illegal_s;
    logic                  unused_instr_s;
    logic pc_write_s, ir_write_s, mem_read_s, mem_write_s, reg_write_s, illegal_pulse_s;

    assign instr_s        = bus.Instr;
    assign opcode_s       = instr_s[6:0];
    assign funct3_s       = instr_s[14:12];
    assign funct7_s       = instr_s[31:25];
    assign alt_s          = instr_s[30];
    assign unused_instr_s = ^{instr_s[24:15], instr_s[11:7]};

    function automatic logic [CONTROL_WIDTH-1:0] alu_arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // The branch compare codes reuse some arithmetic encodings. For example, BNE uses the XOR code.
    function automatic logic [CONTROL_WIDTH-1:0] alu_branch(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_BEQ;
            3'b001:  return ALU_XOR;
            3'b100:  return ALU_SRL;
            3'b101:  return ALU_SRA;
            3'b110:  return ALU_SLT;
            3'b111:  return ALU_SLTU;
            default: return ALU_ADD;
        endcase
    endfunction

    // Flag an unsupported encoding: an unknown opcode, branch funct3 010/011, or a bad R-type funct7.
    always_comb begin
        case (opcode_s)
            OP_LOAD, OP_STORE, OP_ITYPE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: illegal_s = 1'b0;
            OP_RTYPE:  illegal_s = (funct7_s != 7'b0000000) && (funct7_s != 7'b0100000);
            OP_BRANCH: illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            default:   illegal_s = 1'b1;
        endcase
    end

    // Select the next state. MemReady matters only in FETCH, MEMREAD and MEMWRITE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (illegal_s) begin
                    state_d = S_FETCH;
                end else begin
                    case (opcode_s)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_RTYPE:          state_d = S_EXECR;
                        OP_ITYPE:          state_d = S_EXECI;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI, OP_AUIPC:  state_d = S_UPPER;
                        default:           state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = (opcode_s == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = bus.MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JALR:     state_d = S_JAL;
            S_JAL:      state_d = S_ALUWB;
            S_UPPER:    state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ImmSrc follows the opcode in every state.
    always_comb begin
        case (opcode_s)
            OP_STORE:         bus.ImmSrc = 3'b001;
            OP_BRANCH:        bus.ImmSrc = 3'b010;
            OP_JAL:           bus.ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: bus.ImmSrc = 3'b100;
            default:          bus.ImmSrc = 3'b000;
        endcase
    end

    // Decode the outputs from the state. Reset forces every write and access strobe low.
    always_comb begin
        pc_write_s      = 1'b0;
        ir_write_s      = 1'b0;
        mem_read_s      = 1'b0;
        mem_write_s     = 1'b0;
        reg_write_s     = 1'b0;
        illegal_pulse_s = 1'b0;
        bus.AdrSrc      = 1'b0;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ResultSrc   = 2'b00;
        bus.ALUctrl     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read_s    = 1'b1;
                pc_write_s    = bus.MemReady;
                ir_write_s    = bus.MemReady;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_DECODE: begin
                bus.ALUSrcA     = 2'b01;
                bus.ALUSrcB     = 2'b01;
                illegal_pulse_s = illegal_s;
            end
            S_MEMADR, S_JALR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                bus.AdrSrc = 1'b1;
                mem_read_s = 1'b1;
            end
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                reg_write_s   = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc  = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUctrl = alu_arith(funct3_s, alt_s);
            end
            S_EXECI: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
                bus.ALUctrl = alu_arith(funct3_s, (funct3_s == 3'b101) & alt_s);
            end
            S_ALUWB: reg_write_s = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUctrl = alu_branch(funct3_s);
                pc_write_s  = bus.Zero;
            end
            S_JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_UPPER: begin
                bus.ALUSrcA = (opcode_s == OP_LUI) ? 2'b11 : 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            default: bus.ALUctrl = ALU_ADD;
        endcase
        bus.PCWrite      = pc_write_s & ~rst;
        bus.IRWrite      = ir_write_s & ~rst;
        bus.MemRead      = mem_read_s & ~rst;
        bus.MemWrite     = mem_write_s & ~rst;
        bus.RegWrite     = reg_write_s & ~rst;
        bus.IllegalInstr = illegal_pulse_s & ~rst;
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. It walks instruction sequences and compares all outputs each cycle.
module tb_multicycle_control;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    multicycle_control_if #(.CONTROL_WIDTH(4), .DATA_WIDTH(32)) bus ();
    multicycle_control #(.CONTROL_WIDTH(4), .DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [19:0] obs_w;
    assign obs_w = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.AdrSrc,
                    bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.ALUctrl, bus.IllegalInstr};

    function automatic logic [19:0] pk(input logic pcw, input logic irw, input logic mr, input logic mw,
                                       input logic rw, input logic adr, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic ill);
        return {pcw, irw, mr, mw, rw, adr, sa, sb, rs, imm, alu, ill};
    endfunction

    function automatic logic [19:0] fetch_v(input logic [2:0] imm);
        return pk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, imm, 4'b0000, 1'b0);
    endfunction

    function automatic logic [19:0] wb_v(input logic [2:0] imm);
        return pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, imm, 4'b0000, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [19:0] e);
        #1;
        check(tag, {12'b0, obs_w}, {12'b0, e});
    endtask

    // Drive one instruction through FETCH and DECODE. Control ends in the first execution state.
    task automatic run_fd(input string tag, input logic [31:0] instr, input logic [2:0] imm, input logic ill);
        bus.Instr    = instr;
        bus.MemReady = 1'b1;
        chk({tag, "_fetch"}, fetch_v(imm));
        step();
        bus.MemReady = 1'b0;
        chk({tag, "_decode"}, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, imm, 4'b0000, ill));
        step();
        bus.MemReady = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.Instr    = 32'h002081B3;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;
        step();
        step();
        chk("rst_fetch", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 4'b0000, 1'b0));
        rst = 1'b0;

        run_fd("add", 32'h002081B3, 3'b000, 1'b0);
        chk("add_execr", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0));
        step();
        chk("add_aluwb", wb_v(3'b000));
        step();

        run_fd("sub", 32'h402081B3, 3'b000, 1'b0);
        chk("sub_execr", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 4'b0001, 1'b0));
        step();
        chk("sub_aluwb", wb_v(3'b000));
        step();

        run_fd("srai", 32'h4030D093, 3'b000, 1'b0);
        chk("srai_execi", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0111, 1'b0));
        step();
        chk("srai_aluwb", wb_v(3'b000));
        step();

        run_fd("lw", 32'h0000A283, 3'b000, 1'b0);
        bus.MemReady = 1'b0;
        chk("lw_memadr", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 1'b0));
        step();
        for (int i = 0; i < 3; i++) begin
            chk("lw_memread_wait", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0));
            step();
        end
        bus.MemReady = 1'b1;
        chk("lw_memread_done", pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0));
        step();
        chk("lw_memwb", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000, 4'b0000, 1'b0));
        step();

        run_fd("bne0", 32'h00209063, 3'b010, 1'b0);
        bus.Zero = 1'b0;
        chk("bne_z0", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b010, 4'b0010, 1'b0));
        step();
        run_fd("bne1", 32'h00209063, 3'b010, 1'b0);
        bus.Zero = 1'b1;
        chk("bne_z1", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b010, 4'b0010, 1'b0));
        step();
        bus.Zero = 1'b0;

        run_fd("ill_op0", 32'h00000000, 3'b000, 1'b1);
        run_fd("ill_br010", 32'h0020A063, 3'b010, 1'b1);
        run_fd("ill_f7", 32'h202081B3, 3'b000, 1'b1);

        run_fd("jalr", 32'h000080E7, 3'b000, 1'b0);
        chk("jalr_tgt", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 4'b0000, 1'b0));
        step();
        chk("jalr_jal", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0));
        step();
        chk("jalr_aluwb", wb_v(3'b000));
        step();

        run_fd("lui", 32'h000000B7, 3'b100, 1'b0);
        chk("lui_upper", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 3'b100, 4'b0000, 1'b0));
        step();
        chk("lui_aluwb", wb_v(3'b100));
        step();

        run_fd("sw", 32'h0050A023, 3'b001, 1'b0);
        chk("sw_memadr", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b001, 4'b0000, 1'b0));
        step();
        bus.MemReady = 1'b0;
        chk("sw_memwrite", pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 1'b0));
        step();
        chk("sw_hold", pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 1'b0));
        step();
        rst = 1'b1;
        chk("sw_rst", pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b001, 4'b0000, 1'b0));
        step();
        rst          = 1'b0;
        bus.MemReady = 1'b1;
        chk("sw_after_rst", fetch_v(3'b001));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: CONTROL_WIDTH, 4, ALU operation code width; DATA_WIDTH, 32, instruction width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 Instr  in  DATA_WIDTH  instruction register contents (opcode [6:0], funct3 [14:12], funct7[5] = bit 30).
REQ-005 Zero  in  1  ALU compare flag; 1 = branch condition true.
REQ-006 MemReady  in  1  memory handshake; 1 = current access completes this cycle.
REQ-007 PCWrite, IRWrite, MemRead, MemWrite, RegWrite  out  1 each  write and access strobes.
REQ-008 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
REQ-010 ALUSrcB  out  2  00 rs2, 01 immediate, 10 constant 4.
REQ-011 ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result direct.
REQ-012 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from opcode in every state.
REQ-013 ALUctrl  out  CONTROL_WIDTH  ALU operation code.
REQ-014 IllegalInstr  out  1  one-cycle pulse on unsupported encoding.

Function
REQ-015 ALU codes SHALL be: ADD 0000, SUB 0001, XOR 0010, OR 0011, AND 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001; branch compares BEQ 1010, BNE 0010, BLT 0110, BGE 0111, BLTU 1000, BGEU 1001.
REQ-016 Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, UPPER.
REQ-017 FETCH: AdrSrc 0, MemRead 1, ALUSrcA 00, ALUSrcB 10, ADD, ResultSrc 10; PCWrite=IRWrite=MemReady; stay while MemReady=0, else DECODE.
REQ-018 DECODE: ALUSrcA 01, ALUSrcB 01, ADD (target to ALUOut); next by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111/0010111 UPPER; anything else FETCH with IllegalInstr=1.
REQ-019 BRANCH with funct3 010/011, and R-type funct7 other than 0000000/0100000, SHALL also be illegal in DECODE.
REQ-020 MEMADR: ALUSrcA 10, ALUSrcB 01, ADD; next MEMREAD for load, MEMWRITE for store.
REQ-021 MEMREAD: AdrSrc 1, MemRead 1, ResultSrc 00; hold until MemReady=1, then MEMWB.
REQ-022 MEMWB: ResultSrc 01, RegWrite 1; next FETCH.
REQ-023 MEMWRITE: AdrSrc 1, MemWrite 1; hold until MemReady=1, then FETCH; MemWrite SHALL stay asserted through the wait.
REQ-024 EXECR: ALUSrcA 10, ALUSrcB 00; funct3 000 ADD (SUB if funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7[5]), 110 OR, 111 AND; next ALUWB.
REQ-025 EXECI: ALUSrcA 10, ALUSrcB 01; as REQ-024 except funct3 000 always ADD; next ALUWB.
REQ-026 ALUWB: ResultSrc 00, RegWrite 1; next FETCH.
REQ-027 BRANCH: ALUSrcA 10, ALUSrcB 00, ALUctrl per funct3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU), ResultSrc 00, PCWrite=Zero; next FETCH.
REQ-028 JALR: ALUSrcA 10, ALUSrcB 01, ADD (target to ALUOut); next JAL.
REQ-029 JAL: ALUSrcA 01, ALUSrcB 10, ADD, ResultSrc 00, PCWrite 1; next ALUWB (links OldPC+4).
REQ-030 UPPER: ALUSrcB 01, ADD, ALUSrcA 11 for LUI, 01 for AUIPC; next ALUWB.
REQ-031 Outputs not listed for a state SHALL be 0; ALUctrl default ADD.
REQ-032 MemReady SHALL be ignored outside FETCH, MEMREAD, MEMWRITE.

Reset
REQ-033 rst=1 at a rising edge SHALL force FETCH from any state, including mid-wait in MEMREAD/MEMWRITE.
REQ-034 While rst=1, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, IllegalInstr SHALL be 0; after release, first cycle is FETCH.

Verification
REQ-035 add x3,x1,x2 (0x002081B3), MemReady=1 -> FETCH, DECODE, EXECR (ALUctrl 0000), ALUWB RegWrite 1, FETCH: 4 cycles.
REQ-036 lw with MemReady low 3 cycles in MEMREAD -> MemRead held 4 cycles, MEMWB RegWrite 1 once, total 8 cycles.
REQ-037 bne (funct3 001), Zero=0 then Zero=1 -> ALUctrl 0010 in BRANCH, PCWrite 0 then 1.
REQ-038 srai (funct3 101, bit30=1) -> EXECI ALUctrl 0111; sub -> EXECR ALUctrl 0001.
REQ-039 opcode 0000000 -> IllegalInstr pulse in DECODE, no write strobes, next FETCH.
REQ-040 rst asserted during MEMWRITE wait -> MemWrite 0 that cycle, FETCH next edge.
